dm_port_arbiter: RTL and testbench

Arbitrates the single-ported data memory between two requesters. Port C is the M-stage CPU access; port D is a secondary master such as a DMA or debug loader. CPU has fixed priority, bounded by a starvation guard so D always progresses. The block also routes the 1-cycle-latency read data back to the requester that issued the read. It sits between the M stage and the data memory array; the M-stage stall logic consumes c_gnt.

---
 rtl/dm_port_arbiter_if.sv | 49 ++++
 rtl/dm_port_arbiter.sv | 77 +++++++
 tb/tb_dm_port_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/dm_port_arbiter_if.sv
// Bus bundle between the CPU/secondary requesters, the data memory and dm_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface dm_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [3:0]    c_be;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;

  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  c_req, c_we, c_be, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output c_req, c_we, c_be, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Data-memory arbiter: CPU (C) has fixed priority, a starvation guard forces D through,
// and 1-cycle read data is steered back to whichever port issued the read.
module dm_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  dm_port_arbiter_if.slave    bus,
  output logic [3:0]          starve_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_C    = 2'b01,
    OWN_D    = 2'b10
  } owner_t;

  owner_t        rd_owner, rd_owner_nxt;
  logic [3:0]    starve_nxt;
  logic          starve_hit;
  logic          c_win, d_win;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
      rd_owner   <= OWN_NONE;
    end else begin
      starve_cnt <= starve_nxt;
      rd_owner   <= rd_owner_nxt;
    end
  end

  always_comb begin
    c_win        = 1'b0;
    d_win        = 1'b0;
    starve_hit   = (starve_cnt == 4'(STARVE_MAX));
    starve_nxt   = starve_cnt;
    rd_owner_nxt = OWN_NONE;

    // Grants are suppressed combinationally while reset is held low.
    if (reset) begin
      if (bus.d_req && starve_hit) d_win = 1'b1;
      else if (bus.c_req)          c_win = 1'b1;
      else if (bus.d_req)          d_win = 1'b1;
    end

    if (!bus.d_req || d_win)      starve_nxt = '0;
    else if (c_win && !starve_hit) starve_nxt = starve_cnt + 4'd1;

    if (c_win && !bus.c_we)      rd_owner_nxt = OWN_C;
    else if (d_win && !bus.d_we) rd_owner_nxt = OWN_D;
  end

  // Idle cycles park the address/data mux on the C payload.
  assign addr_mux  = d_win ? bus.d_addr  : bus.c_addr;
  assign wdata_mux = d_win ? bus.d_wdata : bus.c_wdata;

  always_comb begin
    bus.c_gnt     = c_win;
    bus.d_gnt     = d_win;
    bus.mem_en    = c_win | d_win;
    bus.mem_we    = (c_win & bus.c_we) | (d_win & bus.d_we);
    bus.mem_be    = d_win ? bus.d_be : (c_win ? bus.c_be : '0);
    bus.mem_addr  = addr_mux;
    bus.mem_wdata = wdata_mux;

    bus.c_rvalid  = reset && (rd_owner == OWN_C);
    bus.d_rvalid  = reset && (rd_owner == OWN_D);
    bus.c_rdata   = bus.c_rvalid ? bus.mem_rdata : '0;
    bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: a transaction-level model predicts every cycle,
// and a negedge monitor pops and compares the predictions against the DUT.
module tb_dm_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] starve_cnt;

  dm_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dm_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .starve_cnt (starve_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cg, dg, en, we;
    logic [3:0]  be;
    logic [31:0] addr, wd;
    logic [3:0]  sc;
    logic        crv, drv;
    logic [31:0] crd, drd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Physical memory responder: 1-cycle read latency, garbage on non-read cycles.
  logic [31:0] phys_mem[64];
  logic        mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) phys_mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) phys_mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? phys_mem[bus.mem_addr[7:2]] : $urandom;
  end

  // Reference model state
  logic [31:0] ref_mem[64];
  int          wait_cnt   = 0;
  int          pend_owner = 0;
  logic [31:0] pend_data  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("c_gnt",      32'(bus.c_gnt),    32'(e.cg));
        chk("d_gnt",      32'(bus.d_gnt),    32'(e.dg));
        chk("mem_en",     32'(bus.mem_en),   32'(e.en));
        chk("mem_we",     32'(bus.mem_we),   32'(e.we));
        chk("mem_be",     32'(bus.mem_be),   32'(e.be));
        chk("starve_cnt", 32'(starve_cnt),   32'(e.sc));
        chk("c_rvalid",   32'(bus.c_rvalid), 32'(e.crv));
        chk("d_rvalid",   32'(bus.d_rvalid), 32'(e.drv));
        chk("c_rdata",    bus.c_rdata,       e.crd);
        chk("d_rdata",    bus.d_rdata,       e.drd);
        if (e.en) begin
          chk("mem_addr",  bus.mem_addr,  e.addr);
          chk("mem_wdata", bus.mem_wdata, e.wd);
        end
      end
    end
  end

  // One clock cycle of stimulus; predicts the cycle and advances the model.
  task automatic step(input logic rst,
                      input logic cr, input logic cw, input logic [3:0] cb,
                      input logic [31:0] ca, input logic [31:0] cd,
                      input logic dr, input logic dw, input logic [3:0] db,
                      input logic [31:0] da, input logic [31:0] dd,
                      output logic cg, output logic dg);
    exp_t        e;
    int          idx;
    int          new_owner;
    logic [31:0] new_data;
    @(posedge clk);
    #1;
    reset = rst;
    bus.c_req = cr; bus.c_we = cw; bus.c_be = cb; bus.c_addr = ca; bus.c_wdata = cd;
    bus.d_req = dr; bus.d_we = dw; bus.d_be = db; bus.d_addr = da; bus.d_wdata = dd;

    e.cg = 1'b0; e.dg = 1'b0;
    if (rst) begin
      if (dr && wait_cnt == SM) e.dg = 1'b1;
      else if (cr)              e.cg = 1'b1;
      else if (dr)              e.dg = 1'b1;
    end
    e.en   = e.cg | e.dg;
    e.we   = e.cg ? cw : (e.dg ? dw : 1'b0);
    e.be   = e.cg ? cb : (e.dg ? db : 4'b0);
    e.addr = e.dg ? da : ca;
    e.wd   = e.dg ? dd : cd;
    e.sc   = 4'(wait_cnt);
    e.crv  = rst && (pend_owner == 1);
    e.drv  = rst && (pend_owner == 2);
    e.crd  = e.crv ? pend_data : '0;
    e.drd  = e.drv ? pend_data : '0;
    exp_q.push_back(e);

    new_owner = 0;
    new_data  = '0;
    if (e.en) begin
      idx = int'(e.addr[7:2]);
      if (e.we) begin
        for (int b = 0; b < 4; b++)
          if (e.be[b]) ref_mem[idx][8*b +: 8] = e.wd[8*b +: 8];
      end else begin
        new_owner = e.cg ? 1 : 2;
        new_data  = ref_mem[idx];
      end
    end

    if (!rst) begin
      wait_cnt   = 0;
      pend_owner = 0;
    end else begin
      if (!dr || e.dg)  wait_cnt = 0;
      else if (e.cg)    wait_cnt = (wait_cnt < SM) ? wait_cnt + 1 : SM;
      pend_owner = new_owner;
      pend_data  = new_data;
    end
    cg = e.cg;
    dg = e.dg;
  endtask

  task automatic idle(input logic rst);
    logic g0, g1;
    step(rst, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, g0, g1);
  endtask

  initial begin : stim
    logic        cg, dg;
    logic        c_pend, d_pend;
    logic        cw, dw;
    logic [3:0]  cb, db;
    logic [31:0] ca, cd, da, dd;
    logic        rst;

    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    reset = 1'b0;
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_be = '0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;

    repeat (3) idle(1'b0);
    repeat (3) idle(1'b1);

    // CPU read of the preloaded 0xDEADBEEF word
    step(1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, cg, dg);
    idle(1'b1);

    // Sustained contention: C wins four times, then D is forced through
    repeat (12)
      step(1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b1, 4'hC, 32'h8, 32'hA5A5_0000, cg, dg);
    idle(1'b1);

    // D partial write, then read it back through D
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'h12345678, cg, dg);
    idle(1'b1);
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, cg, dg);
    idle(1'b1);

    // Back-to-back reads C then D
    step(1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, cg, dg);
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0, cg, dg);
    idle(1'b1);

    // Reset right after a granted read drops the return
    step(1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, cg, dg);
    step(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0, cg, dg);
    idle(1'b0);
    idle(1'b1);

    // Randomized traffic with req/payload held until granted
    c_pend = 1'b0; d_pend = 1'b0;
    cw = 1'b0; dw = 1'b0; cb = '0; db = '0; ca = '0; cd = '0; da = '0; dd = '0;
    for (int n = 0; n < 2000; n++) begin
      if (!c_pend && $urandom_range(0, 3) != 0) begin
        c_pend = 1'b1;
        cw = 1'($urandom); cb = 4'($urandom_range(1, 15));
        ca = {24'h0, 6'($urandom), 2'b00}; cd = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1'b1;
        dw = 1'($urandom); db = 4'($urandom_range(1, 15));
        da = {24'h0, 6'($urandom), 2'b00}; dd = $urandom;
      end
      rst = ($urandom_range(0, 63) != 0);
      step(rst, c_pend, cw, cb, ca, cd, d_pend, dw, db, da, dd, cg, dg);
      if (cg) c_pend = 1'b0;
      if (dg) d_pend = 1'b0;
    end

    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
